// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one bundle carrying the dmem and imem requester ports
// and the shared memory port seen by mem_port_arbiter.
//   slave  : the arbiter's view (requests in, responses out, memory port out)
//   master : the surrounding pipeline and memory (the opposite directions)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  // data requester (dmem, requester 0)
  logic              dmemreq_val;
  logic              dmemreq_rdy;
  logic              dmemreq_type;
  logic [ADDR_W-1:0] dmemreq_addr;
  logic [31:0]       dmemreq_data;
  logic              dmemresp_val;
  logic [31:0]       dmemresp_data;

  // instruction requester (imem, requester 1), read only
  logic              imemreq_val;
  logic              imemreq_rdy;
  logic [ADDR_W-1:0] imemreq_addr;
  logic              imemresp_val;
  logic [31:0]       imemresp_data;

  // shared single-ported memory
  logic              memreq_val;
  logic              memreq_rdy;
  logic              memreq_type;
  logic [ADDR_W-1:0] memreq_addr;
  logic [31:0]       memreq_data;
  logic              memresp_val;
  logic [31:0]       memresp_data;

  // sticky protocol error flag
  logic              proto_err;

  modport slave (
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_data,
    output dmemreq_rdy, dmemresp_val, dmemresp_data,
    input  imemreq_val, imemreq_addr,
    output imemreq_rdy, imemresp_val, imemresp_data,
    output memreq_val, memreq_type, memreq_addr, memreq_data,
    input  memreq_rdy, memresp_val, memresp_data,
    output proto_err
  );

  modport master (
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_data,
    input  dmemreq_rdy, dmemresp_val, dmemresp_data,
    output imemreq_val, imemreq_addr,
    input  imemreq_rdy, imemresp_val, imemresp_data,
    input  memreq_val, memreq_type, memreq_addr, memreq_data,
    output memreq_rdy, memresp_val, memresp_data,
    input  proto_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (imem, owner 1) and load/store (dmem, owner 0). Requests are granted onto the
// memory port; an ownership FIFO remembers who issued each outstanding
// transaction so in-order responses are steered back with zero latency.
//
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate (the requester that was not granted last wins). When
// undefined, dmem has fixed priority over imem.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  localparam logic OWNER_DMEM = 1'b0;
  localparam logic OWNER_IMEM = 1'b1;

  // ownership FIFO and occupancy
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PTR_W-1:0]           head_q;
  logic [PTR_W-1:0]           tail_q;
  logic [CNT_W-1:0]           count_q;
  logic                       proto_err_q;

  // per-cycle control
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              space;
  logic              pick_dmem;
  logic              gnt_d;
  logic              gnt_i;
  logic              head_owner;
  logic [ADDR_W-1:0] addr_mux;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // A response pops the head only if something is outstanding; an unexpected
  // response is dropped and flagged instead of corrupting the pointers.
  assign pop = bus.memresp_val & ~empty;

  // A pop this cycle frees a slot, so a full FIFO can still accept a request.
  assign space = ~full | pop;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // On contention the requester not granted last wins; a sole requester wins.
  always_comb begin
    // NOTE: default assignment first so every path drives pick_dmem (no latch).
    pick_dmem = bus.dmemreq_val;
    if (bus.dmemreq_val && bus.imemreq_val) begin
      pick_dmem = (last_grant_q == OWNER_IMEM);
    end
  end

  // Remember which requester the memory last accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= OWNER_IMEM;
    end else if (push) begin
      last_grant_q <= gnt_i;
    end
  end
`else
  // Fixed priority: any dmem request beats a fetch.
  assign pick_dmem = bus.dmemreq_val;
`endif

  assign gnt_d = pick_dmem & space;
  assign gnt_i = bus.imemreq_val & ~pick_dmem & space;

  // A transaction is issued when the memory takes the granted request.
  assign push = (gnt_d | gnt_i) & bus.memreq_rdy;

  // Memory request mux: fetches are always reads, and data is zero unless a
  // dmem request owns the port.
  always_comb begin
    addr_mux = '0;
    if (gnt_d) begin
      addr_mux = bus.dmemreq_addr;
    end else if (gnt_i) begin
      addr_mux = bus.imemreq_addr;
    end
  end

  assign bus.memreq_val  = gnt_d | gnt_i;
  assign bus.memreq_type = gnt_d & bus.dmemreq_type;
  assign bus.memreq_addr = addr_mux;
  assign bus.memreq_data = gnt_d ? bus.dmemreq_data : 32'h0;

  // Ready is the grant qualified by the memory accepting; it never waits on
  // anything beyond the grant itself.
  assign bus.dmemreq_rdy = gnt_d & bus.memreq_rdy;
  assign bus.imemreq_rdy = gnt_i & bus.memreq_rdy;

  // Response steering follows the owner at the FIFO head.
  assign head_owner        = owner_q[head_q];
  assign bus.dmemresp_val  = pop & (head_owner == OWNER_DMEM);
  assign bus.imemresp_val  = pop & (head_owner == OWNER_IMEM);
  assign bus.dmemresp_data = bus.memresp_data;
  assign bus.imemresp_data = bus.memresp_data;

  assign bus.proto_err = proto_err_q;

  // Owner storage: written at the tail on each issued transaction.
  // NOTE: storage is deliberately not reset; count_q/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      owner_q[tail_q] <= gnt_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (bus.memresp_val && empty) begin
      proto_err_q <= 1'b1;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between instruction fetch (imem, requester 1) and load/store (dmem, requester 0) for the five-stage TinyRV1 pipeline.
- Arbitrates val/rdy requests onto the memory port.
- Tracks outstanding transactions in an ownership FIFO and steers each in-order memory response back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered memory transactions (power of two, >=2).
- ADDR_W, 32, request address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dmemreq_val  in  1  data request valid.
- dmemreq_rdy  out  1  data request accepted this cycle when val&rdy.
- dmemreq_type  in  1  0=read, 1=write.
- dmemreq_addr  in  ADDR_W  data request address.
- dmemreq_data  in  32  store data.
- dmemresp_val  out  1  data response valid.
- dmemresp_data  out  32  load data (don't-care for write acks).
- imemreq_val  in  1  fetch request valid (read only).
- imemreq_rdy  out  1  fetch request accepted.
- imemreq_addr  in  ADDR_W  fetch address.
- imemresp_val  out  1  fetch response valid.
- imemresp_data  out  32  fetched instruction.
- memreq_val  out  1  memory request valid.
- memreq_rdy  in  1  memory accepts request.
- memreq_type  out  1  0=read, 1=write.
- memreq_addr  out  ADDR_W  memory address.
- memreq_data  out  32  write data.
- memresp_val  in  1  memory response valid; responses arrive in request order and cannot be back-pressured.
- memresp_data  in  32  memory response data.
- proto_err  out  1  sticky; memresp_val seen with no transaction outstanding.

Behaviour:
- State:
  - owner FIFO, MAX_OUTSTANDING entries x 1 bit (0=dmem, 1=imem).
  - count register, $clog2(MAX_OUTSTANDING+1) bits.
  - last_grant bit (used only with the optional feature).
  - proto_err flop.
- Reset (async, any time including mid-transaction): FIFO empty, count=0, last_grant=1, proto_err=0. In-flight ownership is discarded; memresp_val after reset sets proto_err.
- space = (count < MAX_OUTSTANDING) | (memresp_val & count != 0). A pop in the same cycle frees a slot.
- Grant is combinational, fixed priority:
  - gnt_d = dmemreq_val & space.
  - gnt_i = imemreq_val & ~dmemreq_val & space.
- memreq_val = gnt_d | gnt_i.
- memreq_type/addr/data are muxed from the granted requester. imem type is forced to 0. Data is 0 when no grant.
- dmemreq_rdy = gnt_d & memreq_rdy; imemreq_rdy = gnt_i & memreq_rdy.
- rdy never depends on the requester's own val beyond grant. Requesters must hold val/payload stable until accepted.
- Push: on memreq_val & memreq_rdy, write the owner bit at the tail.
- Pop: on memresp_val & count != 0, read the owner at the head.
- Response steering is combinational, zero latency:
  - dmemresp_val = memresp_val & count != 0 & head==0; imemresp_val likewise for head==1.
  - Both resp_data outputs = memresp_data.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop. Head/tail pointers wrap modulo MAX_OUTSTANDING.
- Full (count==MAX_OUTSTANDING with no pop): memreq_val=0, both rdy=0.
- Empty with memresp_val=1: no resp_val asserted, response dropped, proto_err set and held until reset.
- Outputs with no activity: all val/rdy 0.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- When defined, the grant on contention alternates: the requester not equal to last_grant wins. last_grant updates to the accepted requester on each push.
- A sole requester always wins, regardless of last_grant.
- When undefined, fixed dmem priority as above, and last_grant is unused.

Test Plan:
- Single fetch: imemreq_val=1, addr=0x200, memreq_rdy=1; memresp next cycle data=0x00000013 -> memreq_addr=0x200, type=0, imemreq_rdy=1 in cycle 0; imemresp_val=1, data=0x13 in cycle 1; dmemresp_val=0; count returns to 0.
- Contention: both val, dmem write addr=0x1000 data=0xDEADBEEF -> dmem granted (memreq_type=1, data=0xDEADBEEF), imemreq_rdy=0. Fetch is granted the next cycle. Responses return to dmem then imem in order. With MEM_ARB_ROUND_ROBIN_EN after reset (last_grant=1), dmem wins the first tie and imem wins the second tie.
- Full: memreq_rdy=1 with no responses for 4 fetches -> count=4, memreq_val=0, imemreq_rdy=0. Assert memresp_val in cycle 5 while imemreq_val=1 -> pop and push same cycle, count stays 4.
- Wrap-around: 10 alternating dmem/imem requests, each answered 2 cycles later -> every response is routed to the correct owner across pointer wrap; count never exceeds 3.
- Backpressure: memreq_rdy=0 for 3 cycles with dmemreq_val=1 -> dmemreq_rdy=0 and count=0 throughout. Request accepted on the cycle memreq_rdy=1.
- Error/reset: memresp_val=1 with count=0 -> proto_err=1, no resp_val. Assert rst with 2 outstanding -> count=0 and proto_err=0 immediately, without waiting for a clock edge.
